tank_motion_ctrl: RTL and testbench
===================================

// Module: tank_motion_ctrl
// PURPOSE
//  Per-tank movement/fire controller; the consumer of the wall-collision checker's can_move output.
//  Once per frame it presents the requested direction, samples can_move for that direction and
//  current position, then steps the tank by STEP pixels or holds. One instance per tank.
//  Also owns a fire-request edge detector with a frame-based cooldown.
// PARAMETERS
//  X_SPAWN   10'd64   reset X position (top-left of 32x32 tank)
//  Y_SPAWN   10'd64   reset Y position
//  STEP      10'd1    pixels per frame; must equal the collision checker's step
//  X_MIN     10'd0    leftmost legal X;  X_MAX 10'd639 rightmost pixel column
//  Y_MIN     10'd0    topmost legal Y;   Y_MAX 10'd479 bottom pixel row
//  COOLDOWN  8'd30    frames between accepted shots
// PORTS
//  Clk        in   1   system clock (50 MHz)
//  Reset_n    in   1   asynchronous, active-low reset
//  frame_clk  in   1   VGA vsync, asynchronous to Clk
//  dir_req    in   3   key direction: 0 none, 1 up, 2 right, 3 left, 4 down; 5-7 treated as 0
//  fire_req   in   1   fire key level
//  can_move   in   1   from collision checker, combinational on X_Tank/Y_Tank/tank_dir
//  X_Tank     out  10  tank top-left X
//  Y_Tank     out  10  tank top-left Y
//  tank_dir   out  3   direction presented to collision checker (0 = none)
//  facing     out  3   last non-zero direction; sprite/bullet orientation
//  moving     out  1   1-cycle pulse when a step is committed
//  fire       out  1   1-cycle pulse when a shot is accepted
// BEHAVIOUR
//  Reset (async, Reset_n=0): X_Tank=X_SPAWN, Y_Tank=Y_SPAWN, tank_dir=0, facing=1 (up),
//   moving=0, fire=0, cooldown=0, FSM=IDLE, synchroniser flops=0. Reset mid-FSM aborts the step.
//  frame_clk: 2-flop synchroniser + rising-edge detect -> frame_tick (1 Clk pulse per frame).
//  FSM (states IDLE, PRESENT, SAMPLE):
//   IDLE    : tank_dir=0. On frame_tick: latch dir_req (sanitised) -> tank_dir; go PRESENT.
//             frame_tick with sanitised dir_req=0: stay IDLE, position unchanged.
//   PRESENT : tank_dir stable one full cycle so can_move settles; go SAMPLE.
//   SAMPLE  : if can_move=1 and in-bounds -> apply step, moving=1; always go IDLE, tank_dir->0.
//   Latency: frame_tick to committed position = 3 Clk cycles; dir_req changes after the latch
//   cycle are ignored until the next frame.
//  Step: up Y-=STEP; down Y+=STEP; left X-=STEP; right X+=STEP; 10-bit unsigned.
//  Bounds (checked in SAMPLE, no wrap-around ever):
//   up only if Y_Tank >= Y_MIN+STEP; left only if X_Tank >= X_MIN+STEP;
//   right only if X_Tank+32+STEP <= X_MAX+1; down only if Y_Tank+32+STEP <= Y_MAX+1.
//   Compare in 11 bits; failing bound = hold position, moving=0.
//  facing updates to tank_dir in SAMPLE whenever tank_dir!=0, even if blocked (turn in place).
//  Fire: rising edge of fire_req (Clk domain, registered) with cooldown==0 -> fire=1 for one
//   cycle, cooldown=COOLDOWN. cooldown decrements by 1 per frame_tick, saturates at 0.
//   Held fire_req never re-fires; edge during cooldown is dropped, not queued.
//   Fire edge and frame_tick in the same cycle: fire accepted (if cooldown was 0), cooldown
//   loads COOLDOWN (load wins over decrement).
//  Fire is independent of the movement FSM; both may pulse in the same cycle.
// STRUCTURE
//  tank_pkg: typedef enum logic [2:0] dir_t {DIR_NONE=0, DIR_UP=1, DIR_RIGHT=2, DIR_LEFT=3,
//   DIR_DOWN=4}; TANK_W=10'd32, TANK_H=10'd32; shared with the collision checker and sprite ROM.
//  Sub-module: sync_edge_detect (2-flop sync + rising-edge pulse, async active-low reset),
//   instantiated for frame_clk; fire_req edge uses a single register (already Clk-synchronous).
//  FSM, position datapath and cooldown counter live in this module.
// TESTING
//  1 Reset release, dir_req=2, can_move=1, 5 frames -> X_Tank=69, Y_Tank=64, 5 moving pulses,
//    facing=2; each commit exactly 3 Clk after frame_tick.
//  2 X_Tank=100, dir_req=3, can_move tied 0 -> X_Tank stays 100, moving never pulses,
//    facing=3, tank_dir=3 only during PRESENT/SAMPLE.
//  3 Spawn X=608, dir_req=2 (608+32+1>640), can_move=1 -> X holds 608; Y=0 with dir_req=1
//    -> Y holds 0, no underflow to 1023.
//  4 fire_req held high 100 frames, COOLDOWN=30 -> exactly one fire pulse; release, re-press
//    at frame 20 after shot -> dropped; re-press at frame 31 -> fire pulse.
//  5 Reset_n low during PRESENT with dir_req=4 -> outputs at reset values immediately
//    (async), Y_Tank=Y_SPAWN, no step after release until the next frame_tick.
//  6 dir_req=7 on frame_tick -> FSM stays IDLE, tank_dir=0, position and facing unchanged.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank definitions: direction encoding, sprite size, and movement FSM states.
package tank_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SAMPLE  = 2'd2
    } mv_state_t;

    localparam logic [9:0] TANK_W = 10'd32;
    localparam logic [9:0] TANK_H = 10'd32;

    // Key codes 5..7 are not directions; fold them onto "no movement".
    function automatic dir_t sanitize_dir(input logic [2:0] d);
        return (d > 3'd4) ? DIR_NONE : dir_t'(d);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic Clk,
    input  logic Reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    // [0],[1] are the synchroniser stages; [2] holds the previous synchronised level
    logic [2:0] sync_reg;

    // Shift the asynchronous level through the synchroniser and history flop
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], async_in};
        end
    end

    assign rise_pulse = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-tank movement and fire controller. Each frame it presents the requested direction to
// the collision checker, samples can_move a cycle later and commits a STEP move or holds.
// A fire-key edge detector with a frame-counted cooldown runs alongside.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter logic [9:0] X_SPAWN  = 10'd64,
    parameter logic [9:0] Y_SPAWN  = 10'd64,
    parameter logic [9:0] STEP     = 10'd1,
    parameter logic [9:0] X_MIN    = 10'd0,
    parameter logic [9:0] X_MAX    = 10'd639,
    parameter logic [9:0] Y_MIN    = 10'd0,
    parameter logic [9:0] Y_MAX    = 10'd479,
    parameter logic [7:0] COOLDOWN = 8'd30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [2:0] dir_req,
    input  logic       fire_req,
    input  logic       can_move,
    output logic [9:0] X_Tank,
    output logic [9:0] Y_Tank,
    output logic [2:0] tank_dir,
    output logic [2:0] facing,
    output logic       moving,
    output logic       fire
);

    logic        frame_tick;
    mv_state_t   state_reg, state_next;
    dir_t        dir_reg;
    logic [9:0]  x_reg, y_reg;
    logic [9:0]  x_next, y_next;
    logic [2:0]  facing_reg;
    logic        moving_reg;
    logic        step_ok;
    logic        fire_prev_reg, fire_reg;
    logic [7:0]  cool_reg;
    logic        fire_edge;
    logic [10:0] x_ext, y_ext;

    sync_edge_detect u_frame_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .async_in   (frame_clk),
        .rise_pulse (frame_tick)
    );

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: a frame with no valid direction never leaves IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (frame_tick && (sanitize_dir(dir_req) != DIR_NONE)) state_next = ST_PRESENT;
            ST_PRESENT: state_next = ST_SAMPLE;
            ST_SAMPLE:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the direction is shown to the collision checker only while a move is in flight
    always_comb begin
        tank_dir = (state_reg == ST_IDLE) ? DIR_NONE : dir_reg;
    end

    // Latch the frame's direction once; later key changes wait for the next frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_reg <= DIR_NONE;
        end else if (state_reg == ST_IDLE && frame_tick) begin
            dir_reg <= sanitize_dir(dir_req);
        end
    end

    assign x_ext = {1'b0, x_reg};
    assign y_ext = {1'b0, y_reg};

    // Candidate position and screen-bounds check, widened to 11 bits so nothing wraps
    always_comb begin
        step_ok = 1'b0;
        x_next  = x_reg;
        y_next  = y_reg;
        case (dir_reg)
            DIR_UP: begin
                step_ok = (y_ext >= ({1'b0, Y_MIN} + {1'b0, STEP}));
                y_next  = y_reg - STEP;
            end
            DIR_DOWN: begin
                step_ok = ((y_ext + {1'b0, TANK_H} + {1'b0, STEP}) <= ({1'b0, Y_MAX} + 11'd1));
                y_next  = y_reg + STEP;
            end
            DIR_LEFT: begin
                step_ok = (x_ext >= ({1'b0, X_MIN} + {1'b0, STEP}));
                x_next  = x_reg - STEP;
            end
            DIR_RIGHT: begin
                step_ok = ((x_ext + {1'b0, TANK_W} + {1'b0, STEP}) <= ({1'b0, X_MAX} + 11'd1));
                x_next  = x_reg + STEP;
            end
            default: step_ok = 1'b0;
        endcase
    end

    // Commit the step in SAMPLE; facing turns even when the move is blocked
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_reg      <= X_SPAWN;
            y_reg      <= Y_SPAWN;
            facing_reg <= DIR_UP;
            moving_reg <= 1'b0;
        end else begin
            moving_reg <= 1'b0;
            if (state_reg == ST_SAMPLE) begin
                if (dir_reg != DIR_NONE) facing_reg <= dir_reg;
                if (can_move && step_ok) begin
                    x_reg      <= x_next;
                    y_reg      <= y_next;
                    moving_reg <= 1'b1;
                end
            end
        end
    end

    assign fire_edge = fire_req & ~fire_prev_reg;

    // Fire edge detect and cooldown; a shot reloads the counter even on a frame tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_prev_reg <= 1'b0;
            fire_reg      <= 1'b0;
            cool_reg      <= 8'd0;
        end else begin
            fire_prev_reg <= fire_req;
            fire_reg      <= 1'b0;
            if (fire_edge && cool_reg == 8'd0) begin
                fire_reg <= 1'b1;
                cool_reg <= COOLDOWN;
            end else if (frame_tick && cool_reg != 8'd0) begin
                cool_reg <= cool_reg - 8'd1;
            end
        end
    end

    assign X_Tank = x_reg;
    assign Y_Tank = y_reg;
    assign facing = facing_reg;
    assign moving = moving_reg;
    assign fire   = fire_reg;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl: movement latency, blocking, screen bounds, fire cooldown,
// asynchronous reset mid-move and invalid direction codes.
module tb_tank_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [2:0] dir_req;
    logic       fire_req;
    logic       can_move;
    logic [9:0] X_Tank, Y_Tank;
    logic [2:0] tank_dir, facing;
    logic       moving, fire;

    int n_cmp = 0;
    int n_mis = 0;

    // per-frame observations
    int          mv_at, mv_cnt, fire_at, fire_cnt;
    logic [16:0] td_mask;
    logic [2:0]  td_val;
    int          acc;

    tank_motion_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .dir_req   (dir_req),
        .fire_req  (fire_req),
        .can_move  (can_move),
        .X_Tank    (X_Tank),
        .Y_Tank    (Y_Tank),
        .tank_dir  (tank_dir),
        .facing    (facing),
        .moving    (moving),
        .fire      (fire)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One 16-cycle frame starting at a falling Clk edge. frame_clk rises at the start and
    // falls after cycle 4. press_at: -1 no fire key action, 0 press at frame start,
    // k>0 press after cycle k; a press is released after cycle 10.
    task automatic frame(input int press_at);
        mv_at = 0; mv_cnt = 0; fire_at = 0; fire_cnt = 0; td_mask = '0; td_val = 3'd0;
        if (press_at == 0) fire_req = 1'b1;
        frame_clk = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (moving) begin mv_cnt++; if (mv_at == 0) mv_at = n; end
            if (fire)   begin fire_cnt++; if (fire_at == 0) fire_at = n; end
            if (tank_dir != 3'd0) begin
                td_mask[n] = 1'b1;
                if (n == 3) td_val = tank_dir;
            end
            if (n == 4) frame_clk = 1'b0;
            if (press_at > 0 && n == press_at) fire_req = 1'b1;
            if (press_at >= 0 && n == 10) fire_req = 1'b0;
        end
    endtask

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; dir_req = 3'd0; fire_req = 1'b0; can_move = 1'b0;
        repeat (3) @(negedge Clk);

        // reset state
        check("rst_x", X_Tank, 64);
        check("rst_y", Y_Tank, 64);
        check("rst_dir", tank_dir, 0);
        check("rst_facing", facing, 1);
        check("rst_moving", moving, 0);
        check("rst_fire", fire, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // 1: five frames right, commit lands 3 cycles after frame_tick (cycle 5 of the frame)
        dir_req = 3'd2; can_move = 1'b1;
        acc = 0;
        for (int f = 0; f < 5; f++) begin
            frame(-1);
            acc += mv_cnt;
            check("t1_commit_cycle", mv_at, 5);
            check("t1_dir_window", td_mask, 17'h00018);
        end
        check("t1_moves", acc, 5);
        check("t1_x", X_Tank, 69);
        check("t1_y", Y_Tank, 64);
        check("t1_facing", facing, 2);
        $display("t1 right x5: X=%0d Y=%0d facing=%0d", X_Tank, Y_Tank, facing);

        // 2: reach X=100 then try left with can_move low
        for (int f = 0; f < 31; f++) frame(-1);
        check("t2_x_pre", X_Tank, 100);
        dir_req = 3'd3; can_move = 1'b0;
        frame(-1);
        check("t2_x_hold", X_Tank, 100);
        check("t2_no_move", mv_cnt, 0);
        check("t2_facing", facing, 3);
        check("t2_dir_window", td_mask, 17'h00018);
        check("t2_dir_val", td_val, 3);
        $display("t2 blocked left: X=%0d facing=%0d", X_Tank, facing);

        // 3: right edge and top edge
        dir_req = 3'd2; can_move = 1'b1;
        for (int f = 0; f < 508; f++) frame(-1);
        check("t3_x_edge", X_Tank, 608);
        frame(-1);
        check("t3_x_hold", X_Tank, 608);
        check("t3_x_no_move", mv_cnt, 0);
        check("t3_facing_r", facing, 2);
        dir_req = 3'd1;
        for (int f = 0; f < 64; f++) frame(-1);
        check("t3_y_top", Y_Tank, 0);
        frame(-1);
        check("t3_y_hold", Y_Tank, 0);
        check("t3_y_no_move", mv_cnt, 0);
        check("t3_facing_u", facing, 1);
        $display("t3 edges: X=%0d Y=%0d", X_Tank, Y_Tank);

        // 6: invalid direction code is no movement at all
        dir_req = 3'd7;
        frame(-1);
        check("t6_no_move", mv_cnt, 0);
        check("t6_dir_idle", td_mask, 0);
        check("t6_x", X_Tank, 608);
        check("t6_y", Y_Tank, 0);
        check("t6_facing", facing, 1);
        $display("t6 dir=7: X=%0d Y=%0d facing=%0d", X_Tank, Y_Tank, facing);

        // 4a: fire held for 100 frames gives one shot
        dir_req = 3'd0;
        fire_req = 1'b1;
        frame(-1);
        check("t4_first_shot_cycle", fire_at, 1);
        acc = 0;
        for (int f = 0; f < 99; f++) begin frame(-1); acc += fire_cnt; end
        check("t4_held_no_refire", acc, 0);
        fire_req = 1'b0;
        frame(-1);

        // 4b: shot, press 20 frames later dropped, press 31 frames later accepted
        frame(0);
        check("t4_shot", fire_cnt, 1);
        acc = 0;
        for (int f = 1; f < 20; f++) begin frame(-1); acc += fire_cnt; end
        frame(0);
        check("t4_press20_dropped", fire_cnt, 0);
        for (int f = 21; f < 31; f++) begin frame(-1); acc += fire_cnt; end
        frame(0);
        check("t4_press31_fires", fire_cnt, 1);
        check("t4_idle_frames", acc, 0);
        $display("t4 cooldown: press31 fire_cnt=%0d", fire_cnt);

        // 4c: shot coincident with frame_tick loads the full cooldown
        for (int f = 0; f < 30; f++) frame(-1);
        frame(2);
        check("t4_coincident_shot", fire_cnt, 1);
        for (int f = 1; f < 30; f++) frame(-1);
        frame(0);
        check("t4_coincident_press30_dropped", fire_cnt, 0);
        frame(0);
        check("t4_coincident_press31_fires", fire_cnt, 1);
        $display("t4 coincident: press31 fire_cnt=%0d", fire_cnt);

        // 5: reset during PRESENT aborts the downward step
        dir_req = 3'd4; can_move = 1'b1;
        frame_clk = 1'b1;
        repeat (3) begin @(posedge Clk); @(negedge Clk); end
        check("t5_present_dir", tank_dir, 4);
        Reset_n = 1'b0;
        #1;
        check("t5_rst_x", X_Tank, 64);
        check("t5_rst_y", Y_Tank, 64);
        check("t5_rst_dir", tank_dir, 0);
        check("t5_rst_facing", facing, 1);
        check("t5_rst_moving", moving, 0);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (moving) acc++;
        end
        check("t5_no_step_after_release", acc, 0);
        check("t5_y_after_release", Y_Tank, 64);
        frame(-1);
        check("t5_next_frame_cycle", mv_at, 5);
        check("t5_next_frame_y", Y_Tank, 65);
        check("t5_facing_down", facing, 4);
        $display("t5 reset mid-move: Y=%0d facing=%0d", Y_Tank, facing);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
